// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with run handshake, jumps, call/return stack, fault flag and run-cycle counter
module pc_sequencer #(
  parameter int D  = 12,
  parameter int SD = 4,
  parameter int OW = 8,
  parameter int CW = 16,
  localparam int SPW = $clog2(SD + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req,
  input  logic [D-1:0]   start_addr,
  input  logic           abs_en,
  input  logic [D-1:0]   abs_target,
  input  logic           rel_en,
  input  logic [OW-1:0]  rel_off,
  input  logic           call_en,
  input  logic           ret_en,
  input  logic           halt_in,
  output logic [D-1:0]   prog_ctr,
  output logic           running,
  output logic           done,
  output logic           err,
  output logic [SPW-1:0] sp,
  output logic [CW-1:0]  cycle_cnt
);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [D-1:0]   stk_q [SD];
  logic           push;
  logic [D-1:0]   rel_ext, pc_inc;
  logic [AW-1:0]  rd_idx, wr_idx;
  assign rel_ext = D'($signed(rel_off));
  assign pc_inc  = pc_q + 1'b1;
  assign rd_idx  = AW'(sp_q - 1'b1);
  assign wr_idx  = AW'(sp_q);
  // Next-state logic: run start in IDLE, prioritised PC update in RUN, release in DONE
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        state_d = RUN;
        pc_d    = start_addr;
        sp_d    = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (halt_in) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (ret_en) begin
          if (sp_q == '0) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            pc_d = stk_q[rd_idx];
            sp_d = sp_q - 1'b1;
          end
        end else if (call_en) begin
          if (sp_q == SPW'(SD)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + 1'b1;
            pc_d = abs_target;
          end
        end else if (abs_en) pc_d = abs_target;
        else if (rel_en) pc_d = pc_q + rel_ext;
        else pc_d = pc_inc;
      end
      DONE: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Registered state, PC, stack pointer, fault flag and cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // Return-address storage; contents are meaningless after reset so it has none
  always_ff @(posedge clk) begin
    if (push) stk_q[wr_idx] <= pc_inc;
  end
  assign prog_ctr  = pc_q;
  assign running   = state_q == RUN;
  assign done      = state_q == DONE;
  assign err       = err_q;
  assign sp        = sp_q;
  assign cycle_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus random stimulus against a queue-based reference model
module tb_pc_sequencer;
  localparam int D = 12, SD = 4, OW = 8, CW = 16;
  localparam int PMOD = 1 << D, CMAX = (1 << CW) - 1;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0;
  logic [D-1:0]  start_addr = '0;
  logic          abs_en = 1'b0;
  logic [D-1:0]  abs_target = '0;
  logic          rel_en = 1'b0;
  logic [OW-1:0] rel_off = '0;
  logic          call_en = 1'b0;
  logic          ret_en = 1'b0;
  logic          halt_in = 1'b0;
  logic [D-1:0]  prog_ctr;
  logic          running, done, err;
  logic [2:0]    sp;
  logic [CW-1:0] cycle_cnt;
  int checks = 0, errors = 0;
  int m_st, m_pc, m_err, m_cnt;
  int m_stack[$];

  pc_sequencer #(.D(D), .SD(SD), .OW(OW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .start_addr(start_addr),
    .abs_en(abs_en), .abs_target(abs_target), .rel_en(rel_en), .rel_off(rel_off),
    .call_en(call_en), .ret_en(ret_en), .halt_in(halt_in),
    .prog_ctr(prog_ctr), .running(running), .done(done), .err(err),
    .sp(sp), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_err = 0; m_cnt = 0;
    m_stack.delete();
  endtask

  // Reference behaviour: m_st 0=idle 1=run 2=done, stack is a plain queue
  task automatic model_step();
    int off;
    if (m_st == 0) begin
      if (req) begin
        m_st = 1; m_pc = start_addr; m_err = 0; m_cnt = 0;
        m_stack.delete();
      end
    end else if (m_st == 1) begin
      if (m_cnt < CMAX) m_cnt++;
      if (halt_in) begin
        m_st = 2; m_err = 0;
      end else if (ret_en) begin
        if (m_stack.size() == 0) begin m_st = 2; m_err = 1; end
        else m_pc = m_stack.pop_back();
      end else if (call_en) begin
        if (m_stack.size() == SD) begin m_st = 2; m_err = 1; end
        else begin m_stack.push_back((m_pc + 1) % PMOD); m_pc = abs_target; end
      end else if (abs_en) m_pc = abs_target;
      else if (rel_en) begin
        off = (int'(rel_off) >= (1 << (OW - 1))) ? int'(rel_off) - (1 << OW) : int'(rel_off);
        m_pc = ((m_pc + off) % PMOD + PMOD) % PMOD;
      end else m_pc = (m_pc + 1) % PMOD;
    end else if (!req) m_st = 0;
  endtask

  task automatic cmp_all();
    chk("prog_ctr", prog_ctr, m_pc);
    chk("running", running, m_st == 1);
    chk("done", done, m_st == 2);
    chk("err", err, m_err);
    chk("sp", sp, m_stack.size());
    chk("cycle_cnt", cycle_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic ctl(input bit h, input bit r, input bit c, input bit a, input bit rl);
    halt_in = h; ret_en = r; call_en = c; abs_en = a; rel_en = rl;
  endtask

  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1 model_reset();
    chk("async_rst_pc", prog_ctr, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_cnt", cycle_cnt, 0);
    chk("async_rst_sp", sp, 0);
    cmp_all();
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    cmp_all();
    reset = 1'b1;
    start_addr = 12'h010; req = 1'b1;
    tick();
    chk("start_pc", prog_ctr, 'h010);
    chk("start_running", running, 1);
    chk("start_cnt", cycle_cnt, 0);
    tick(); chk("seq_pc1", prog_ctr, 'h011); chk("seq_cnt1", cycle_cnt, 1);
    tick(); chk("seq_pc2", prog_ctr, 'h012);
    tick(); chk("seq_pc3", prog_ctr, 'h013);
    ctl(1, 0, 0, 0, 0);
    tick();
    chk("halt_done", done, 1); chk("halt_err", err, 0);
    chk("halt_pc", prog_ctr, 'h013); chk("halt_cnt", cycle_cnt, 4);
    ctl(0, 0, 0, 0, 0);
    tick(); chk("done_persist", done, 1);
    req = 1'b0; tick(); chk("idle_done", done, 0); chk("idle_running", running, 0);
    req = 1'b1; tick(); chk("restart_pc", prog_ctr, 'h010); chk("restart_cnt", cycle_cnt, 0);
    abs_target = 12'h020; ctl(0, 0, 0, 1, 0); tick(); chk("abs_pc", prog_ctr, 'h020);
    rel_off = 8'hF8; ctl(0, 0, 0, 0, 1); tick(); chk("rel_neg", prog_ctr, 'h018);
    rel_off = 8'h7F; tick(); chk("rel_pos", prog_ctr, 'h097);
    abs_target = 12'h300; ctl(0, 0, 0, 1, 1); tick(); chk("abs_over_rel", prog_ctr, 'h300);
    abs_target = 12'hFFF; ctl(0, 0, 0, 1, 0); tick();
    ctl(0, 0, 0, 0, 0); tick(); chk("wrap_pc", prog_ctr, 'h000); chk("wrap_running", running, 1);
    abs_target = 12'h005; ctl(0, 0, 0, 1, 0); tick();
    abs_target = 12'h100; ctl(0, 0, 1, 0, 0); tick(); chk("call1_pc", prog_ctr, 'h100);
    ctl(0, 0, 0, 0, 0); tick();
    abs_target = 12'h200; ctl(0, 0, 1, 0, 0); tick(); chk("call2_pc", prog_ctr, 'h200); chk("call2_sp", sp, 2);
    ctl(0, 1, 0, 0, 0); tick(); chk("ret1_pc", prog_ctr, 'h102);
    tick(); chk("ret2_pc", prog_ctr, 'h006); chk("ret2_sp", sp, 0);
    for (int i = 0; i < 4; i++) begin
      abs_target = 12'h400 + 12'(i * 16); ctl(0, 0, 1, 0, 0); tick();
    end
    abs_target = 12'h500; tick();
    chk("ovf_done", done, 1); chk("ovf_err", err, 1); chk("ovf_sp", sp, 4); chk("ovf_pc", prog_ctr, 'h430);
    ctl(0, 0, 0, 0, 0); req = 1'b0; tick();
    req = 1'b1; tick(); req = 1'b0;
    ctl(0, 1, 0, 0, 0); tick();
    chk("udf_done", done, 1); chk("udf_err", err, 1); chk("udf_sp", sp, 0); chk("udf_pc", prog_ctr, 'h010);
    ctl(0, 0, 0, 0, 0); tick();
    req = 1'b1; tick(); req = 1'b0;
    abs_target = 12'h050; ctl(0, 0, 1, 0, 0); tick();
    ctl(1, 1, 1, 0, 0); tick();
    chk("prio_done", done, 1); chk("prio_err", err, 0); chk("prio_sp", sp, 1); chk("prio_pc", prog_ctr, 'h050);
    ctl(0, 0, 0, 0, 0); tick();
    req = 1'b1; tick(); req = 1'b0;
    tick(); tick();
    reset_pulse();
    for (int n = 0; n < 3000; n++) begin
      req = $urandom_range(0, 1);
      start_addr = D'($urandom);
      abs_target = D'($urandom);
      rel_off = OW'($urandom);
      ctl($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) abs_target = 12'hFFF;
      tick();
      if ($urandom_range(0, 299) == 0) reset_pulse();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program sequencer for the next-generation core. It replaces the fixed-width PC and the hard-wired "done at PC 15" detection. It adds a req/done run handshake, absolute and signed-relative jumps, call/return through a return-address stack, halt detection, fault reporting and a run-cycle counter. It sits between the control decoder/PC LUT and the instruction ROM, and its prog_ctr output drives the ROM address.

Parameters:
D, 12, program counter width in bits
SD, 4, return-address stack depth in entries (at least 1)
OW, 8, relative offset width in bits (at most D), two's complement
CW, 16, run-cycle counter width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  run request, level-sensitive
start_addr  input  D  PC loaded on run start
abs_en  input  1  absolute jump: PC <= abs_target
abs_target  input  D  absolute target from PC LUT
rel_en  input  1  relative jump: PC <= PC + sext(rel_off)
rel_off  input  OW  signed relative offset
call_en  input  1  push PC+1, then PC <= abs_target
ret_en  input  1  PC <= popped return address
halt_in  input  1  decoder halt, ends run
prog_ctr  output  D  current PC (ROM address)
running  output  1  high in RUN
done  output  1  high in DONE
err  output  1  stack fault caused the run to end (valid with done)
sp  output  $clog2(SD+1)  stack occupancy, 0..SD
cycle_cnt  output  CW  count of RUN cycles in the current or last run

Behaviour:
- Reset (reset low, asynchronous): state IDLE, prog_ctr=0, running=0, done=0, err=0, sp=0, cycle_cnt=0, stack contents don't-care.
- States are IDLE, RUN and DONE, and all outputs are registered.
- IDLE: PC holds. If req=1 at a clock edge: prog_ctr<=start_addr, sp<=0, err<=0, cycle_cnt<=0, go to RUN.
  - The first RUN cycle presents start_addr, so latency from req is 1 cycle.
- RUN: each edge increments cycle_cnt, saturating at 2^CW-1. Next PC uses fixed priority, highest first:
  1. halt_in=1: PC holds; go to DONE, err=0.
  2. ret_en=1:
     - sp=0 is underflow: PC holds; go to DONE, err=1.
     - Otherwise PC <= stack[sp-1], sp <= sp-1.
  3. call_en=1:
     - sp=SD is overflow: PC holds; go to DONE, err=1.
     - Otherwise stack[sp] <= PC+1 (mod 2^D), sp <= sp+1, PC <= abs_target.
  4. abs_en=1: PC <= abs_target.
  5. rel_en=1: PC <= (PC + sign-extend(rel_off) to D bits) mod 2^D.
  6. Otherwise PC <= PC+1 mod 2^D. PC 2^D-1 wraps to 0 without a fault.
- Lower-priority enables asserted in the same cycle are ignored entirely: no stack or PC side effect.
- req is ignored during RUN. Dropping req does not abort a run.
- DONE: done=1, PC, sp, err and cycle_cnt hold for inspection. When req=0 at an edge, go to IDLE; done falls on the next cycle.
  - If req stays high, DONE persists and the block does not auto-restart.
- Entering RUN from IDLE requires req=1 in IDLE, so a new run needs a req low/high sequence after done.
- Reset asserted mid-run aborts immediately to the reset values. There is no partial-state retention.
- Control inputs other than req are only sampled in RUN.

Test Plan:
- Reset and start: D=12, reset low then high, start_addr=0x010, req=1 for one edge. Required: prog_ctr sequence 0x010, 0x011, 0x012, …; running=1; cycle_cnt increments by one per cycle.
- Halt and handshake: halt_in at PC 0x013 with req held high. Required: done=1, err=0, PC holds 0x013, cycle_cnt=4.
  - Then drop req: IDLE on the next edge, done=0.
  - A second req restarts at start_addr with cycle_cnt=0.
- Jumps: at PC 0x020 apply rel_off=0xF8 (-8) and go to 0x018; at 0x018 apply rel_off=0x7F and go to 0x097.
  - At PC 0x097, abs_en=1 with rel_en=1 and abs_target=0x300 must go to 0x300; abs wins.
  - Wrap case: from 0xFFF with no enables, PC must go to 0x000.
- Call/return nesting, SD=4: call at 0x005 (target 0x100) and call at 0x101 (target 0x200). Required: sp=2.
  - Then ret, ret: PC 0x102 then 0x006, sp=0.
- Stack faults:
  - Five nested calls: the fifth gives done=1, err=1, sp=4, PC held at the caller.
  - A new run then ret_en on its first cycle: done=1, err=1, sp=0.
- Priority and asynchronous reset:
  - halt_in, ret_en and call_en together: halt wins, sp unchanged.
  - reset pulsed low between edges mid-run: outputs go to reset values immediately, without waiting for a clock edge.
